// File: rtl/synth_pkg.sv
// Shared definitions for the multi-channel tone synthesiser: waveform modes and noise LFSR.
package synth_pkg;

    typedef enum logic [1:0] {
        MODE_SQUARE  = 2'd0,
        MODE_PULSE25 = 2'd1,
        MODE_NOISE   = 2'd2,
        MODE_RSVD    = 2'd3
    } mode_e;

    localparam int          LFSR_W      = 15;
    localparam logic [14:0] LFSR_SEED   = 15'h0001;
    localparam int          LFSR_TAP_HI = 14;
    localparam int          LFSR_TAP_LO = 13;

    // Fibonacci step for x^15 + x^14 + 1, shifting towards the MSB.
    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
        return {s[LFSR_W-2:0], s[LFSR_TAP_HI] ^ s[LFSR_TAP_LO]};
    endfunction

endpackage

// File: rtl/tone_channel.sv
// One tone channel: interval counter, phase, noise LFSR, pending period slot and waveform select.
module tone_channel
    import synth_pkg::*;
#(
    parameter int HP_W = 10
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            active_i,
    input  logic            ld_i,
    input  logic [HP_W-1:0] ld_hp_i,
    input  logic [1:0]      ld_mode_i,
    output logic            pend_o,
    output logic            audio_o
);

    localparam logic [HP_W-1:0] HP_ONE = HP_W'(1);

    logic [HP_W-1:0]   ctr_q, ctr_d;
    logic [HP_W-1:0]   hp_cur_q, hp_cur_d;
    logic [HP_W-1:0]   hp_pend_q, hp_pend_d;
    mode_e             mode_cur_q, mode_cur_d;
    mode_e             mode_pend_q, mode_pend_d;
    logic              pend_q, pend_d;
    logic [1:0]        phase_q, phase_d;
    logic [LFSR_W-1:0] lfsr_q, lfsr_d;
    logic              boundary;
    logic              wave;

    // Next-state: inactive channels sit in their start state; active ones count intervals
    // and only adopt a new period at an interval boundary, so the output never glitches.
    always_comb begin
        ctr_d       = ctr_q;
        hp_cur_d    = hp_cur_q;
        hp_pend_d   = hp_pend_q;
        mode_cur_d  = mode_cur_q;
        mode_pend_d = mode_pend_q;
        pend_d      = pend_q;
        phase_d     = phase_q;
        lfsr_d      = lfsr_q;
        boundary    = active_i && (hp_cur_q != '0) && (ctr_q == hp_cur_q);

        if (!active_i) begin
            ctr_d   = HP_ONE;
            phase_d = 2'd0;
            lfsr_d  = LFSR_SEED;
            if (pend_q) begin
                hp_cur_d   = hp_pend_q;
                mode_cur_d = mode_pend_q;
                pend_d     = 1'b0;
            end
            if (ld_i) begin
                hp_cur_d   = ld_hp_i;
                mode_cur_d = mode_e'(ld_mode_i);
                pend_d     = 1'b0;
            end
        end else begin
            if (hp_cur_q == '0) begin
                ctr_d = HP_ONE;
            end else if (boundary) begin
                ctr_d   = HP_ONE;
                phase_d = phase_q + 2'd1;
                lfsr_d  = lfsr_next(lfsr_q);
                if (pend_q) begin
                    hp_cur_d   = hp_pend_q;
                    mode_cur_d = mode_pend_q;
                    pend_d     = 1'b0;
                end
            end else begin
                ctr_d = ctr_q + HP_ONE;
            end
            // A load only arrives with the slot empty; a silent channel takes it at once,
            // a running one parks it until its current interval ends.
            if (ld_i) begin
                if (hp_cur_q == '0) begin
                    hp_cur_d   = ld_hp_i;
                    mode_cur_d = mode_e'(ld_mode_i);
                    ctr_d      = HP_ONE;
                    phase_d    = 2'd0;
                end else begin
                    hp_pend_d   = ld_hp_i;
                    mode_pend_d = mode_e'(ld_mode_i);
                    pend_d      = 1'b1;
                end
            end
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctr_q      <= HP_ONE;
            hp_cur_q   <= '0;
            mode_cur_q <= MODE_SQUARE;
            pend_q     <= 1'b0;
            phase_q    <= 2'd0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            ctr_q      <= ctr_d;
            hp_cur_q   <= hp_cur_d;
            mode_cur_q <= mode_cur_d;
            pend_q     <= pend_d;
            phase_q    <= phase_d;
            lfsr_q     <= lfsr_d;
        end
    end

    // Pending payload; only meaningful while pend_q is set, so it needs no reset.
    always_ff @(posedge clk_i) begin
        hp_pend_q   <= hp_pend_d;
        mode_pend_q <= mode_pend_d;
    end

    // Waveform select; the reserved mode behaves as square.
    always_comb begin
        case (mode_cur_q)
            MODE_PULSE25: wave = (phase_q == 2'd3);
            MODE_NOISE:   wave = lfsr_q[0];
            default:      wave = phase_q[0];
        endcase
        audio_o = wave & active_i & (hp_cur_q != '0);
    end

    assign pend_o = pend_q;

endmodule

// File: rtl/tone_synth_multi.sv
// Multi-channel tone synthesiser: load decode, ready mux, channel array and registered mixer.
module tone_synth_multi
    import synth_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int HP_W     = 10,
    parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    parameter int MIX_W    = $clog2(CHANNELS + 1)
) (
    input  logic                synth_clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] ch_active,
    input  logic                ld_valid,
    output logic                ld_ready,
    input  logic [CH_W-1:0]     ld_chan,
    input  logic [HP_W-1:0]     ld_hp,
    input  logic [1:0]          ld_mode,
    output logic [CHANNELS-1:0] audio,
    output logic [MIX_W-1:0]    audio_mix,
    output logic                audio_any
);

    logic [CHANNELS-1:0] pend;
    logic [CHANNELS-1:0] ld_sel;
    logic [MIX_W-1:0]    mix_q, mix_d;
    logic                any_q, any_d;

    // Ready follows the addressed channel's pending slot; out-of-range loads are accepted and dropped.
    always_comb begin
        ld_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (ld_chan == CH_W'(i)) begin
                ld_ready = ~pend[i];
            end
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        assign ld_sel[g] = ld_valid & ld_ready & (ld_chan == CH_W'(g));

        tone_channel #(
            .HP_W (HP_W)
        ) u_chan (
            .clk_i     (synth_clk),
            .rst_i     (rst),
            .active_i  (ch_active[g]),
            .ld_i      (ld_sel[g]),
            .ld_hp_i   (ld_hp),
            .ld_mode_i (ld_mode),
            .pend_o    (pend[g]),
            .audio_o   (audio[g])
        );
    end

    // Mixer input: population count and OR of the per-channel outputs.
    always_comb begin
        mix_d = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            mix_d = mix_d + MIX_W'(audio[i]);
        end
        any_d = |audio;
    end

    // Mixer output register, one cycle behind the channel outputs.
    always_ff @(posedge synth_clk or posedge rst) begin
        if (rst) begin
            mix_q <= '0;
            any_q <= 1'b0;
        end else begin
            mix_q <= mix_d;
            any_q <= any_d;
        end
    end

    assign audio_mix = mix_q;
    assign audio_any = any_q;

endmodule

// File: tb/tb_tone_synth_multi.sv
// Bench for tone_synth_multi: table vectors, directed corner sequences and randomized traffic
// checked against an interval-counting reference model.
module tb_tone_synth_multi;

    logic       synth_clk = 1'b0;
    logic       rst;
    logic [2:0] ch_active;
    logic       ld_valid;
    logic       ld_ready;
    logic [1:0] ld_chan;
    logic [9:0] ld_hp;
    logic [1:0] ld_mode;
    logic [2:0] audio;
    logic [1:0] audio_mix;
    logic       audio_any;

    int checks = 0;
    int errors = 0;

    always #5 synth_clk = ~synth_clk;

    tone_synth_multi #(.CHANNELS(3), .HP_W(10)) dut (
        .synth_clk (synth_clk),
        .rst       (rst),
        .ch_active (ch_active),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_chan   (ld_chan),
        .ld_hp     (ld_hp),
        .ld_mode   (ld_mode),
        .audio     (audio),
        .audio_mix (audio_mix),
        .audio_any (audio_any)
    );

    // Reference model: each channel is described by its period, waveform, how many cycles
    // of the current interval have elapsed and how many whole intervals have passed.
    int m_hp[3], m_mode[3], m_t[3], m_k[3], m_php[3], m_pmode[3], m_lfsr[3];
    bit m_pend[3];
    int m_mix;
    bit m_any;

    typedef struct {
        logic [2:0] act;
        logic       vld;
        logic [1:0] chan;
        logic [9:0] hp;
        logic [1:0] mode;
        logic [2:0] e_audio;
        logic [1:0] e_mix;
        logic       e_rdy;
    } vec_t;

    vec_t tbl[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            m_hp[c] = 0; m_mode[c] = 0; m_t[c] = 0; m_k[c] = 0;
            m_php[c] = 0; m_pmode[c] = 0; m_lfsr[c] = 1; m_pend[c] = 0;
        end
        m_mix = 0;
        m_any = 0;
    endtask

    function automatic bit m_wave(input int c);
        if (!ch_active[c] || m_hp[c] == 0) return 1'b0;
        case (m_mode[c])
            1:       return (m_k[c] % 4) == 3;
            2:       return (m_lfsr[c] & 1) != 0;
            default: return (m_k[c] % 2) == 1;
        endcase
    endfunction

    function automatic logic [2:0] m_audio();
        logic [2:0] a;
        for (int c = 0; c < 3; c++) a[c] = m_wave(c);
        return a;
    endfunction

    function automatic logic m_ready();
        if (int'(ld_chan) >= 3) return 1'b1;
        return !m_pend[ld_chan];
    endfunction

    // One clock: compare every output against the model, then advance the model across the edge.
    task automatic step();
        logic [2:0] ea;
        logic       er;
        bit         acc, ld;
        int         old_hp;
        #1;
        ea = m_audio();
        er = m_ready();
        check("audio", audio, ea);
        check("ld_ready", ld_ready, er);
        check("audio_mix", audio_mix, m_mix);
        check("audio_any", audio_any, m_any);
        acc = ld_valid && er;
        @(posedge synth_clk);
        m_mix = int'(ea[0]) + int'(ea[1]) + int'(ea[2]);
        m_any = |ea;
        for (int c = 0; c < 3; c++) begin
            ld = acc && (int'(ld_chan) == c);
            if (!ch_active[c]) begin
                m_t[c] = 0; m_k[c] = 0; m_lfsr[c] = 1;
                if (m_pend[c]) begin
                    m_hp[c] = m_php[c]; m_mode[c] = m_pmode[c]; m_pend[c] = 0;
                end
                if (ld) begin
                    m_hp[c] = ld_hp; m_mode[c] = ld_mode;
                end
            end else begin
                old_hp = m_hp[c];
                if (old_hp != 0) begin
                    if (m_t[c] == old_hp - 1) begin
                        m_t[c] = 0;
                        m_k[c]++;
                        m_lfsr[c] = ((m_lfsr[c] << 1) & 32'h7fff) | (((m_lfsr[c] >> 14) ^ (m_lfsr[c] >> 13)) & 1);
                        if (m_pend[c]) begin
                            m_hp[c] = m_php[c]; m_mode[c] = m_pmode[c]; m_pend[c] = 0;
                        end
                    end else begin
                        m_t[c]++;
                    end
                end
                if (ld) begin
                    if (old_hp == 0) begin
                        m_hp[c] = ld_hp; m_mode[c] = ld_mode; m_t[c] = 0; m_k[c] = 0;
                    end else begin
                        m_php[c] = ld_hp; m_pmode[c] = ld_mode; m_pend[c] = 1;
                    end
                end
            end
        end
        @(negedge synth_clk);
    endtask

    task automatic load(input int ch, input int hp, input int mode);
        ld_valid = 1'b1;
        ld_chan  = 2'(ch);
        ld_hp    = 10'(hp);
        ld_mode  = 2'(mode);
        step();
        ld_valid = 1'b0;
    endtask

    // Steps until audio[ch] changes; n is the number of clocks it took (capped at 40).
    task automatic measure(input int ch, output int n);
        logic s;
        s = audio[ch];
        n = 0;
        while (n < 40) begin
            step();
            n++;
            if (audio[ch] !== s) break;
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        check("rst_audio", audio, 0);
        check("rst_mix", audio_mix, 0);
        check("rst_any", audio_any, 0);
        model_reset();
        @(posedge synth_clk);
        @(negedge synth_clk);
        rst = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int n, highs, idx;

        rst = 1'b1; ch_active = '0; ld_valid = 0; ld_chan = 0; ld_hp = 0; ld_mode = 0;
        model_reset();
        repeat (2) @(posedge synth_clk);
        @(negedge synth_clk);
        check("reset_audio", audio, 0);
        check("reset_mix", audio_mix, 0);
        check("reset_any", audio_any, 0);
        check("reset_ready", ld_ready, 1);
        rst = 1'b0;

        // ch0 square hp=4: four cycles low, four high; mix lags audio by one cycle.
        tbl[0] = '{3'b001, 1'b1, 2'd0, 10'd4, 2'd0, 3'b000, 2'd0, 1'b1};
        for (int i = 1; i < 14; i++) tbl[i] = '{3'b001, 1'b0, 2'd0, 10'd0, 2'd0, 3'b000, 2'd0, 1'b1};
        for (int i = 5; i <= 8; i++) tbl[i].e_audio = 3'b001;
        for (int i = 6; i <= 9; i++) tbl[i].e_mix = 2'd1;
        tbl[13].e_audio = 3'b001;
        for (int i = 0; i < 14; i++) begin
            ch_active = tbl[i].act; ld_valid = tbl[i].vld; ld_chan = tbl[i].chan;
            ld_hp = tbl[i].hp; ld_mode = tbl[i].mode;
            #1;
            check($sformatf("tbl%0d_audio", i), audio, tbl[i].e_audio);
            check($sformatf("tbl%0d_mix", i), audio_mix, tbl[i].e_mix);
            check($sformatf("tbl%0d_ready", i), ld_ready, tbl[i].e_rdy);
            step();
        end
        ld_valid = 1'b0;

        // ch1 hp=3, then hp=5 mid-interval: current interval finishes, later ones are 5.
        ch_active = 3'b011;
        load(1, 3, 0);
        repeat (4) step();
        load(1, 5, 0);
        ld_chan = 2'd1;
        #1 check("pend_ready_low", ld_ready, 0);
        measure(1, n); check("ch1_first_gap", n, 1);
        check("pend_ready_back", ld_ready, 1);
        measure(1, n); check("ch1_gap5_a", n, 5);
        measure(1, n); check("ch1_gap5_b", n, 5);

        // hp=0 silences ch0 at its next boundary; hp=2 afterwards applies immediately.
        load(0, 0, 0);
        ld_chan = 2'd0;
        n = 0;
        while (n < 10 && ld_ready !== 1'b1) begin step(); n++; end
        check("hp0_promoted", ld_ready, 1);
        repeat (3) begin step(); check("hp0_silent", audio[0], 0); end
        load(0, 2, 0);
        #1 check("hp2_no_pending", ld_ready, 1);
        measure(0, n); check("hp2_first_toggle", n, 2);

        // ch2 pulse25 hp=2: high 2 cycles out of 8.
        load(2, 2, 1);
        ch_active = 3'b111;
        highs = 0;
        repeat (16) begin step(); if (audio[2] === 1'b1) highs++; end
        check("pulse25_highs", highs, 4);
        // Noise hp=1 from the seed: 1, 0, 0.
        ch_active = 3'b011;
        load(2, 1, 2);
        ch_active = 3'b111;
        #1 check("noise_s0", audio[2], 1);
        step(); check("noise_s1", audio[2], 0);
        step(); check("noise_s2", audio[2], 0);

        // All channels square hp=1 in phase, then drop ch1 while high.
        ch_active = 3'b000;
        step();
        load(0, 1, 0); load(1, 1, 0); load(2, 1, 0);
        ch_active = 3'b111;
        #1 check("sync_low", audio, 0);
        step(); check("sync_high", audio, 7);
        step(); check("sync_mix3", audio_mix, 3);
        step(); check("sync_mix0", audio_mix, 0);
        ch_active = 3'b101;
        #1 check("drop_ch1_audio", audio, 5);
        step(); check("drop_ch1_mix", audio_mix, 2);

        // Reset while loads are pending.
        ch_active = 3'b000;
        step();
        load(0, 9, 0); load(1, 9, 0);
        ch_active = 3'b111;
        repeat (2) step();
        load(0, 7, 0); load(1, 6, 1);
        ld_chan = 2'd0; #1 check("pre_rst_pend0", ld_ready, 0);
        ld_chan = 2'd1; #1 check("pre_rst_pend1", ld_ready, 0);
        do_reset();
        for (int c = 0; c < 3; c++) begin
            ld_chan = 2'(c);
            #1 check($sformatf("post_rst_ready%0d", c), ld_ready, 1);
        end
        step();

        // Randomized traffic against the model, with one asynchronous reset in the middle.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                idx = $urandom_range(0, 2);
                ch_active[idx] = ~ch_active[idx];
            end
            ld_valid = ($urandom_range(0, 5) == 0);
            ld_chan  = 2'($urandom_range(0, 3));
            ld_hp    = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 9));
            ld_mode  = 2'($urandom_range(0, 3));
            if (i == 1500) do_reset();
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
